// File: rtl/matrix_mul_seq_ctrl.sv
// Sequential NxN unsigned matrix multiplier: serial load of A then B, N^3 cycles
// on one shared MAC, then a row-major result stream with valid/ready handshakes.
module matrix_mul_seq_ctrl #(
  parameter int N  = 4,
  parameter int DW = 4,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(N);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int LW = $clog2(2 * NN);

  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
  localparam logic [LW-1:0] P_LAST   = LW'(2 * NN - 1);
  localparam logic [LW-1:0] P_B      = LW'(NN);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] p_q, p_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] k_q, k_d;
  logic [OW-1:0] acc_q, acc_d;
  logic          done_q, done_d;

  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] b_q [NN];
  logic [OW-1:0] y_q [NN];

  logic          a_we, b_we, y_we;
  logic [IW-1:0] a_waddr, b_waddr;
  logic [IW-1:0] a_raddr, b_raddr, y_addr;
  logic [OW-1:0] prod;
  logic          beat;

  // i/j double as the output row/column during DRAIN, so one address serves
  // both the Y write in COMPUTE and the Y read in DRAIN.
  assign a_raddr = IW'(i_q) * IW'(N) + IW'(k_q);
  assign b_raddr = IW'(k_q) * IW'(N) + IW'(j_q);
  assign y_addr  = IW'(i_q) * IW'(N) + IW'(j_q);
  assign a_waddr = IW'(p_q);
  assign b_waddr = IW'(p_q - P_B);
  assign prod    = OW'(a_q[a_raddr]) * OW'(b_q[b_raddr]);

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != LOAD);
  assign done      = done_q;
  assign beat      = in_valid && in_ready;
  assign out_data  = out_valid ? y_q[y_addr] : '0;
  assign out_row   = out_valid ? i_q : '0;
  assign out_col   = out_valid ? j_q : '0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    y_we    = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (beat) begin
          a_we = (p_q < P_B);
          b_we = (p_q >= P_B);
          if (p_q == P_LAST) begin
            p_d     = '0;
            state_d = COMPUTE;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end

      COMPUTE: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
        if (k_q == IDX_LAST) begin
          y_we = 1'b1;
          k_d  = '0;
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              i_d     = '0;
              state_d = DRAIN;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              i_d     = '0;
              done_d  = 1'b1;
              state_d = LOAD;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the matrix stores carry no reset; every entry is rewritten before it
  // is read, so resetting them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (a_we) a_q[a_waddr] <= in_data;
    if (b_we) b_q[b_waddr] <= in_data;
    if (y_we) y_q[y_addr]  <= acc_d;
  end

endmodule
